stream_rr_arbiter_bank: RTL and testbench

- Bank of M_DATA_COUNT independent round-robin packet arbiters, one per output stream. Each arbiter chooses which input stream owns its output.
- Drives the grant / arbiter-ready sideband of the crossbar data communication net.
- A grant is locked for a whole packet and released only after the handshake of the beat that carries last.

---
 rtl/stream_rr_arbiter_bank.sv | 102 ++++++++++
 tb/tb_stream_rr_arbiter_bank.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter_bank.sv
// Bank of independent round-robin packet arbiters, one per output stream.
// Each output locks onto one input for a whole packet and releases it after the last beat's handshake.
module stream_rr_arbiter_bank #(
    parameter  int S_DATA_COUNT = 2,
    parameter  int M_DATA_COUNT = 3,
    localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT),
    localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i,
    input  logic [S_DATA_COUNT-1:0]                   s_valid_i,
    input  logic [S_DATA_COUNT-1:0]                   s_last_i,
    input  logic [M_DATA_COUNT-1:0]                   m_ready_i,
    output logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] grant_o,
    output logic [M_DATA_COUNT-1:0]                   arbiter_ready_o,
    output logic [S_DATA_COUNT-1:0]                   busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    for (genvar j = 0; j < M_DATA_COUNT; j++) begin : g_arb
        state_t                  state, state_next;
        logic [T_ID___WIDTH-1:0] grant, grant_next;
        logic [T_ID___WIDTH-1:0] ptr, ptr_next;
        logic [T_ID___WIDTH-1:0] winner;
        logic [S_DATA_COUNT-1:0] req;
        logic                    release_beat;

        always_comb begin
            req = '0;
            for (int k = 0; k < S_DATA_COUNT; k++) begin
                req[k] = s_valid_i[k] && (s_dest_i[k] == T_DEST_WIDTH'(j));
            end
        end

        // Scan backwards so the last hit is the first requester after ptr.
        always_comb begin
            winner = ptr;
            for (int i = S_DATA_COUNT; i >= 1; i--) begin
                if (req[(int'(ptr) + i) % S_DATA_COUNT]) begin
                    winner = T_ID___WIDTH'((int'(ptr) + i) % S_DATA_COUNT);
                end
            end
        end

        assign release_beat = s_valid_i[grant] && s_last_i[grant] && m_ready_i[j]
                              && (s_dest_i[grant] == T_DEST_WIDTH'(j));

        always_comb begin
            state_next = state;
            grant_next = grant;
            ptr_next   = ptr;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant_next = winner;
                        ptr_next   = winner;
                        state_next = LOCK;
                    end
                end
                LOCK: begin
                    if (release_beat) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        // Pointer resets to the top id so input 0 wins first.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state <= IDLE;
                grant <= '0;
                ptr   <= T_ID___WIDTH'(S_DATA_COUNT - 1);
            end else begin
                state <= state_next;
                grant <= grant_next;
                ptr   <= ptr_next;
            end
        end

        assign arbiter_ready_o[j] = (state == LOCK);
        assign grant_o[j]         = grant;
    end

    always_comb begin
        busy_o = '0;
        for (int j = 0; j < M_DATA_COUNT; j++) begin
            for (int k = 0; k < S_DATA_COUNT; k++) begin
                if (arbiter_ready_o[j] && (grant_o[j] == T_ID___WIDTH'(k))) begin
                    busy_o[k] = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter_bank.sv
// Self-checking bench for stream_rr_arbiter_bank (S=2, M=3): per-cycle stimulus rows carry
// the expected outputs, which are queued on drive and popped for comparison after the edge.
module tb_stream_rr_arbiter_bank;

    localparam int S  = 2;
    localparam int M  = 3;
    localparam int IW = 1;
    localparam int DW = 2;

    logic                   clk;
    logic                   rst_i;
    logic [S-1:0][DW-1:0]   s_dest;
    logic [S-1:0]           s_valid;
    logic [S-1:0]           s_last;
    logic [M-1:0]           m_ready;
    logic [M-1:0][IW-1:0]   grant;
    logic [M-1:0]           arb_ready;
    logic [S-1:0]           busy;

    typedef struct {
        logic       rst;
        logic [1:0] valid;
        logic [1:0] last;
        logic [1:0] d0;
        logic [1:0] d1;
        logic [2:0] mrdy;
        logic [2:0] e_rdy;
        logic [2:0] e_gnt;
        logic [2:0] e_gmask;
        logic [1:0] e_busy;
    } row_t;

    row_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    stream_rr_arbiter_bank #(
        .S_DATA_COUNT(S),
        .M_DATA_COUNT(M)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .s_dest_i       (s_dest),
        .s_valid_i      (s_valid),
        .s_last_i       (s_last),
        .m_ready_i      (m_ready),
        .grant_o        (grant),
        .arbiter_ready_o(arb_ready),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs, queues its expectation, and returns 1 time unit after the edge.
    task automatic drive_cycle(input row_t r);
        rst_i     = r.rst;
        s_valid   = r.valid;
        s_last    = r.last;
        s_dest[0] = r.d0;
        s_dest[1] = r.d1;
        m_ready   = r.mrdy;
        exp_q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        row_t rows[$];
        row_t e;
        logic [2:0] g;
        for (int i = 0; i < 12; i++) begin
            rows.push_back('{(i < 2) ? 1'b1 : 1'b0, 2'b00, 2'b00, 2'd0, 2'd0, 3'b000,
                             3'b000, 3'b000, 3'b111, 2'b00});
        end
        foreach (rows[i]) begin
            drive_cycle(rows[i]);
            e = exp_q.pop_front();
            g = grant;
            checks += 3;
            if (arb_ready !== e.e_rdy) begin
                failures++;
                $display("[TB] FAIL reset[%0d] arbiter_ready got %b expected %b", i, arb_ready, e.e_rdy);
            end
            if ((g & e.e_gmask) !== (e.e_gnt & e.e_gmask)) begin
                failures++;
                $display("[TB] FAIL reset[%0d] grant got %b expected %b", i, g, e.e_gnt);
            end
            if (busy !== e.e_busy) begin
                failures++;
                $display("[TB] FAIL reset[%0d] busy got %b expected %b", i, busy, e.e_busy);
            end
        end
    endtask

    task automatic test_single_packet();
        row_t rows[$];
        row_t e;
        logic [2:0] g;
        rows.push_back('{0, 2'b10, 2'b00, 2'd0, 2'd2, 3'b100, 3'b100, 3'b100, 3'b100, 2'b10});
        rows.push_back('{0, 2'b10, 2'b00, 2'd0, 2'd2, 3'b100, 3'b100, 3'b100, 3'b100, 2'b10});
        rows.push_back('{0, 2'b10, 2'b00, 2'd0, 2'd2, 3'b100, 3'b100, 3'b100, 3'b100, 2'b10});
        rows.push_back('{0, 2'b10, 2'b10, 2'd0, 2'd2, 3'b100, 3'b000, 3'b100, 3'b111, 2'b00});
        rows.push_back('{0, 2'b00, 2'b00, 2'd0, 2'd2, 3'b100, 3'b000, 3'b100, 3'b111, 2'b00});
        foreach (rows[i]) begin
            drive_cycle(rows[i]);
            e = exp_q.pop_front();
            g = grant;
            checks += 3;
            if (arb_ready !== e.e_rdy) begin
                failures++;
                $display("[TB] FAIL single_packet[%0d] arbiter_ready got %b expected %b", i, arb_ready, e.e_rdy);
            end
            if ((g & e.e_gmask) !== (e.e_gnt & e.e_gmask)) begin
                failures++;
                $display("[TB] FAIL single_packet[%0d] grant got %b expected %b", i, g, e.e_gnt);
            end
            if (busy !== e.e_busy) begin
                failures++;
                $display("[TB] FAIL single_packet[%0d] busy got %b expected %b", i, busy, e.e_busy);
            end
        end
    endtask

    task automatic test_round_robin();
        row_t rows[$];
        row_t e;
        logic [2:0] g;
        for (int p = 0; p < 4; p++) begin
            logic [1:0] lst;
            logic       who;
            who = p[0];
            lst = who ? 2'b10 : 2'b01;
            rows.push_back('{0, 2'b11, 2'b00, 2'd0, 2'd0, 3'b001, 3'b001, {2'b00, who}, 3'b001,
                             who ? 2'b10 : 2'b01});
            rows.push_back('{0, 2'b11, 2'b00, 2'd0, 2'd0, 3'b001, 3'b001, {2'b00, who}, 3'b001,
                             who ? 2'b10 : 2'b01});
            rows.push_back('{0, 2'b11, lst,   2'd0, 2'd0, 3'b001, 3'b000, 3'b000, 3'b000, 2'b00});
        end
        rows.push_back('{0, 2'b00, 2'b00, 2'd0, 2'd0, 3'b001, 3'b000, 3'b101, 3'b111, 2'b00});
        foreach (rows[i]) begin
            drive_cycle(rows[i]);
            e = exp_q.pop_front();
            g = grant;
            checks += 3;
            if (arb_ready !== e.e_rdy) begin
                failures++;
                $display("[TB] FAIL round_robin[%0d] arbiter_ready got %b expected %b", i, arb_ready, e.e_rdy);
            end
            if ((g & e.e_gmask) !== (e.e_gnt & e.e_gmask)) begin
                failures++;
                $display("[TB] FAIL round_robin[%0d] grant got %b expected %b", i, g, e.e_gnt);
            end
            if (busy !== e.e_busy) begin
                failures++;
                $display("[TB] FAIL round_robin[%0d] busy got %b expected %b", i, busy, e.e_busy);
            end
        end
    endtask

    task automatic test_hold_lock();
        row_t rows[$];
        row_t e;
        logic [2:0] g;
        rows.push_back('{0, 2'b01, 2'b00, 2'd1, 2'd1, 3'b010, 3'b010, 3'b000, 3'b010, 2'b01});
        rows.push_back('{0, 2'b01, 2'b00, 2'd1, 2'd1, 3'b010, 3'b010, 3'b000, 3'b010, 2'b01});
        rows.push_back('{0, 2'b10, 2'b00, 2'd1, 2'd1, 3'b010, 3'b010, 3'b000, 3'b010, 2'b01});
        rows.push_back('{0, 2'b10, 2'b01, 2'd1, 2'd1, 3'b010, 3'b010, 3'b000, 3'b010, 2'b01});
        rows.push_back('{0, 2'b11, 2'b01, 2'd1, 2'd1, 3'b000, 3'b010, 3'b000, 3'b010, 2'b01});
        rows.push_back('{0, 2'b11, 2'b01, 2'd1, 2'd1, 3'b010, 3'b000, 3'b000, 3'b010, 2'b00});
        rows.push_back('{0, 2'b10, 2'b00, 2'd1, 2'd1, 3'b010, 3'b010, 3'b010, 3'b010, 2'b10});
        rows.push_back('{0, 2'b10, 2'b10, 2'd1, 2'd1, 3'b010, 3'b000, 3'b010, 3'b010, 2'b00});
        rows.push_back('{0, 2'b00, 2'b00, 2'd1, 2'd1, 3'b010, 3'b000, 3'b111, 3'b111, 2'b00});
        foreach (rows[i]) begin
            drive_cycle(rows[i]);
            e = exp_q.pop_front();
            g = grant;
            checks += 3;
            if (arb_ready !== e.e_rdy) begin
                failures++;
                $display("[TB] FAIL hold_lock[%0d] arbiter_ready got %b expected %b", i, arb_ready, e.e_rdy);
            end
            if ((g & e.e_gmask) !== (e.e_gnt & e.e_gmask)) begin
                failures++;
                $display("[TB] FAIL hold_lock[%0d] grant got %b expected %b", i, g, e.e_gnt);
            end
            if (busy !== e.e_busy) begin
                failures++;
                $display("[TB] FAIL hold_lock[%0d] busy got %b expected %b", i, busy, e.e_busy);
            end
        end
    endtask

    task automatic test_parallel();
        row_t rows[$];
        row_t e;
        logic [2:0] g;
        rows.push_back('{0, 2'b11, 2'b00, 2'd0, 2'd2, 3'b101, 3'b101, 3'b100, 3'b101, 2'b11});
        rows.push_back('{0, 2'b11, 2'b00, 2'd0, 2'd2, 3'b101, 3'b101, 3'b100, 3'b101, 2'b11});
        rows.push_back('{0, 2'b11, 2'b01, 2'd0, 2'd2, 3'b101, 3'b100, 3'b100, 3'b100, 2'b10});
        rows.push_back('{0, 2'b10, 2'b10, 2'd0, 2'd2, 3'b101, 3'b000, 3'b110, 3'b111, 2'b00});
        rows.push_back('{0, 2'b00, 2'b00, 2'd0, 2'd2, 3'b101, 3'b000, 3'b110, 3'b111, 2'b00});
        foreach (rows[i]) begin
            drive_cycle(rows[i]);
            e = exp_q.pop_front();
            g = grant;
            checks += 3;
            if (arb_ready !== e.e_rdy) begin
                failures++;
                $display("[TB] FAIL parallel[%0d] arbiter_ready got %b expected %b", i, arb_ready, e.e_rdy);
            end
            if ((g & e.e_gmask) !== (e.e_gnt & e.e_gmask)) begin
                failures++;
                $display("[TB] FAIL parallel[%0d] grant got %b expected %b", i, g, e.e_gnt);
            end
            if (busy !== e.e_busy) begin
                failures++;
                $display("[TB] FAIL parallel[%0d] busy got %b expected %b", i, busy, e.e_busy);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        row_t rows[$];
        row_t e;
        logic [2:0] g;
        rows.push_back('{0, 2'b01, 2'b00, 2'd0, 2'd0, 3'b001, 3'b001, 3'b110, 3'b111, 2'b01});
        rows.push_back('{0, 2'b01, 2'b00, 2'd0, 2'd0, 3'b001, 3'b001, 3'b110, 3'b111, 2'b01});
        rows.push_back('{1, 2'b11, 2'b00, 2'd0, 2'd0, 3'b001, 3'b000, 3'b000, 3'b111, 2'b00});
        rows.push_back('{0, 2'b11, 2'b00, 2'd0, 2'd0, 3'b001, 3'b001, 3'b000, 3'b001, 2'b01});
        rows.push_back('{0, 2'b11, 2'b01, 2'd0, 2'd0, 3'b001, 3'b000, 3'b000, 3'b000, 2'b00});
        rows.push_back('{0, 2'b00, 2'b00, 2'd0, 2'd0, 3'b001, 3'b000, 3'b000, 3'b111, 2'b00});
        foreach (rows[i]) begin
            drive_cycle(rows[i]);
            e = exp_q.pop_front();
            g = grant;
            checks += 3;
            if (arb_ready !== e.e_rdy) begin
                failures++;
                $display("[TB] FAIL reset_mid_packet[%0d] arbiter_ready got %b expected %b", i, arb_ready, e.e_rdy);
            end
            if ((g & e.e_gmask) !== (e.e_gnt & e.e_gmask)) begin
                failures++;
                $display("[TB] FAIL reset_mid_packet[%0d] grant got %b expected %b", i, g, e.e_gnt);
            end
            if (busy !== e.e_busy) begin
                failures++;
                $display("[TB] FAIL reset_mid_packet[%0d] busy got %b expected %b", i, busy, e.e_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_hold_lock();
        test_parallel();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
